// File: rtl/if_stage.sv
// if_stage: instruction fetch stage of the MIPS core.
// Owns the PC and fetches one word at a time from instruction memory over a
// req/ready handshake. Each returned word goes into the IF/ID register, and
// its opcode is passed to the control unit. Hazard stalls and
// branch/jump redirects are handled here.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   imem_addr/req  fetch address (word aligned) and request, held until ready
//   imem_ready     memory completes the request this cycle, imem_rdata valid
//   imem_rdata     fetched instruction word
//   stall          hold IF/ID contents (hazard unit)
//   branch_taken   redirect to branch_target (wins over jump)
//   jump           redirect to {pc_plus4[31:28], jump_index, 2'b00}
//   instr/opcode   IF/ID instruction and its [31:26] field
//   pc_plus4       IF/ID PC+4 of instr
//   valid          IF/ID holds a real instruction
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  // FETCH: a request for pc is outstanding.
  // HOLD:  a word fetched during a stall waits in the skid register, and no request is made.
  // DRAIN: a redirect arrived while a request was pending. The memory
  //        response is awaited and then discarded before fetching redir_pc.
  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_HOLD  = 2'b01,
    S_DRAIN = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic [31:0] redir_pc_q, redir_pc_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_inc;

  always_comb begin
    redirect = branch_taken | jump;
    // The jump region comes from the PC+4 of the ID-stage instruction, which
    // is the instruction currently held in IF/ID.
    target   = branch_taken ? (branch_target & ~32'd3)
                            : {pc_plus4_q[31:28], jump_index, 2'b00};
    pc_inc   = pc_q + 32'd4;

    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    skid_d     = skid_q;
    skid_pc4_d = skid_pc4_q;
    redir_pc_d = redir_pc_q;

    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          if (redirect) begin
            pc_d    = target;
            instr_d = '0;
            valid_d = 1'b0;
          end else if (stall) begin
            // The word cannot enter IF/ID yet. It is parked so the
            // completed request does not have to be repeated.
            skid_d     = imem_rdata;
            skid_pc4_d = pc_inc;
            pc_d       = pc_inc;
            state_d    = S_HOLD;
          end else begin
            instr_d    = imem_rdata;
            pc_plus4_d = pc_inc;
            valid_d    = 1'b1;
            pc_d       = pc_inc;
          end
        end else begin
          if (redirect) begin
            // The pending request cannot be withdrawn, so its response
            // is drained before the new target is fetched.
            redir_pc_d = target;
            instr_d    = '0;
            valid_d    = 1'b0;
            state_d    = S_DRAIN;
          end else if (!stall) begin
            instr_d = '0;
            valid_d = 1'b0;
          end
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_d    = target;
          instr_d = '0;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end else if (!stall) begin
          instr_d    = skid_q;
          pc_plus4_d = skid_pc4_q;
          valid_d    = 1'b1;
          state_d    = S_FETCH;
        end
      end

      S_DRAIN: begin
        instr_d = '0;
        valid_d = 1'b0;
        if (redirect) redir_pc_d = target;
        if (imem_ready) begin
          pc_d    = redirect ? target : redir_pc_q;
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC & ~32'd3;
      instr_q    <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
      skid_q     <= '0;
      skid_pc4_q <= '0;
      redir_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      skid_q     <= skid_d;
      skid_pc4_q <= skid_pc4_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  assign imem_addr = pc_q;
  assign imem_req  = (state_q != S_HOLD);
  assign instr     = instr_q;
  assign opcode    = instr_q[31:26];
  assign pc_plus4  = pc_plus4_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: a memory that answers every address with a known
// word, directed fetch scenarios, and then a long randomized run. A
// transaction-level reference model predicts the fetch address and the
// sequence of instructions that should enter IF/ID.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = '0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc_plus4;
  logic        valid;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_req      (imem_req),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_index    (jump_index),
    .instr         (instr),
    .opcode        (opcode),
    .pc_plus4      (pc_plus4),
    .valid         (valid)
  );

  always #5 clk = ~clk;

  // The word stored at byte address a is (a/4)+1.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) + 32'd1;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc4;
  } ifid_t;

  ifid_t       sb[$];     // instructions expected to enter IF/ID
  ifid_t       held[$];   // a fetched word waiting out a stall
  logic [31:0] m_pc;      // address being (or next to be) requested
  logic [31:0] m_pc4;     // PC+4 of the instruction currently in IF/ID
  logic [31:0] drain_to;
  bit          draining;
  bit          m_valid;

  task automatic model_reset();
    m_pc = 32'h0; m_pc4 = 32'h0; drain_to = 32'h0;
    draining = 1'b0; m_valid = 1'b0;
    held.delete(); sb.delete();
  endtask

  task automatic load(input ifid_t w);
    sb.push_back(w);
    m_pc4   = w.pc4;
    m_valid = 1'b1;
  endtask

  task automatic model_step();
    bit          redir;
    logic [31:0] tgt;
    ifid_t       w;
    redir = branch_taken || jump;
    tgt   = branch_taken ? {branch_target[31:2], 2'b00}
                         : {m_pc4[31:28], jump_index, 2'b00};
    if (held.size() != 0) begin
      if (redir) begin held.delete(); m_pc = tgt; m_valid = 1'b0; end
      else if (!stall) begin w = held.pop_front(); load(w); end
    end else if (draining) begin
      m_valid = 1'b0;
      if (redir) drain_to = tgt;
      if (imem_ready) begin m_pc = drain_to; draining = 1'b0; end
    end else if (imem_ready) begin
      w.word = mem_word(m_pc);
      w.pc4  = m_pc + 32'd4;
      if (redir) begin
        m_pc = tgt; m_valid = 1'b0;
      end else begin
        m_pc = m_pc + 32'd4;
        if (stall) held.push_back(w);
        else load(w);
      end
    end else if (redir) begin
      draining = 1'b1; drain_to = tgt; m_valid = 1'b0;
    end else if (!stall) begin
      m_valid = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst_n) model_step();
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    ifid_t e;
    ifid_t last;
    bit    hold_edge;
    bit    live;
    bit    is_new;
    last = '0;
    forever begin
      @(posedge clk);
      hold_edge = stall && !(branch_taken || jump);
      live      = rst_n;
      #2;
      if (live && rst_n) begin
        chk("imem_req", 32'(imem_req), 32'(held.size() == 0));
        if (held.size() == 0) chk("imem_addr", imem_addr, m_pc);
        chk("valid", 32'(valid), 32'(m_valid));
        // A valid IF/ID after an edge without a hold is a newly loaded instruction.
        is_new = valid && !hold_edge;
        chk("new_instr", 32'(is_new), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          sb.delete();
          if (is_new) begin
            chk("instr", instr, e.word);
            chk("pc_plus4", pc_plus4, e.pc4);
            chk("opcode", 32'(opcode), 32'(e.word[31:26]));
            last = e;
          end
        end else if (valid) begin
          chk("instr_held", instr, last.word);
          chk("pc_plus4_held", pc_plus4, last.pc4);
        end else begin
          chk("instr_bubble", instr, 32'h0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit rdy, input bit stl, input bit bt, input logic [31:0] btt,
                     input bit jp, input logic [25:0] ji);
    imem_ready = rdy; stall = stl; branch_taken = bt; branch_target = btt;
    jump = jp; jump_index = ji;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_opcode"}, 32'(opcode), 32'h0);
    chk({tag, "_pc_plus4"}, pc_plus4, 32'h0);
    chk({tag, "_valid"}, 32'(valid), 32'h0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
  endtask

  initial begin : driver
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    chk("req_after_release", 32'(imem_req), 32'h1);
    chk("addr_after_release", imem_addr, 32'h0);

    // Zero-wait stream
    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    chk("stream_instr3", instr, 32'd3);
    chk("stream_pc4_12", pc_plus4, 32'd12);
    chk("stream_addr12", imem_addr, 32'd12);
    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    chk("stream_instr6", instr, 32'd6);

    // Reset mid-stream
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Wait states: ready every third cycle
    for (int i = 0; i < 9; i++) cyc((i % 3) == 2, 0, 0, 0, 0, 0);
    chk("wait_instr3", instr, 32'd3);
    chk("wait_addr12", imem_addr, 32'd12);

    // Stall with a completing fetch goes through the skid register
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("skid_req0", 32'(imem_req), 32'h0);
    chk("skid_keep4", instr, 32'd4);
    cyc(0, 1, 0, 0, 0, 0);
    chk("skid_still4", instr, 32'd4);
    cyc(0, 0, 0, 0, 0, 0);
    chk("skid_out5", instr, 32'd5);
    chk("skid_addr20", imem_addr, 32'd20);
    chk("skid_req1", 32'(imem_req), 32'h1);

    // Branch flush during a completing fetch
    cyc(1, 0, 1, 32'h40, 0, 0);
    chk("br_valid0", 32'(valid), 32'h0);
    chk("br_addr40", imem_addr, 32'h40);
    cyc(1, 0, 0, 0, 0, 0);
    chk("br_instr", instr, 32'h11);

    // Jump while a fetch is pending, then drain
    cyc(1, 0, 1, 32'h1000_0004, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("drain_pc4", pc_plus4, 32'h1000_0008);
    cyc(0, 0, 0, 0, 1, 26'h10);
    chk("drain_addr_hold", imem_addr, 32'h1000_0008);
    chk("drain_valid0", 32'(valid), 32'h0);
    repeat (3) begin
      cyc(0, 1, 0, 0, 0, 0);
      chk("drain_addr_wait", imem_addr, 32'h1000_0008);
    end
    cyc(1, 0, 0, 0, 0, 0);
    chk("drain_addr_jump", imem_addr, 32'h1000_0040);
    chk("drain_discard", 32'(valid), 32'h0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("drain_instr", instr, 32'h0400_0011);

    // Branch and jump together: branch wins
    cyc(1, 0, 1, 32'h200, 1, 26'h3FF_FFFF);
    chk("both_addr", imem_addr, 32'h200);

    // Newer redirects during a drain, including one coinciding with ready
    cyc(0, 0, 1, 32'h300, 0, 0);
    cyc(1, 0, 1, 32'h400, 0, 0);
    chk("drain_coincide", imem_addr, 32'h400);
    cyc(0, 0, 1, 32'h500, 0, 0);
    cyc(0, 0, 1, 32'h600, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("drain_newest", imem_addr, 32'h600);

    // PC wrap and target alignment
    cyc(1, 0, 1, 32'hFFFF_FFF9, 0, 0);
    chk("wrap_align", imem_addr, 32'hFFFF_FFF8);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("wrap_addr0", imem_addr, 32'h0);
    chk("wrap_pc4_0", pc_plus4, 32'h0);
    chk("wrap_opcode", 32'(opcode), 32'h10);

    // Randomized run
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] t;
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                                      : 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("rnd_rst");
        @(negedge clk);
        rst_n = 1'b1;
      end
      cyc($urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0,
          $urandom_range(0, 11) == 0, t,
          $urandom_range(0, 11) == 0, 26'($urandom));
    end

    cyc(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction fetch stage for the MIPS core.
- Owns the PC and issues word fetches to instruction memory over a req/ready handshake.
- Captures each returned word into the IF/ID register and presents its opcode to the control unit.
- Handles hazard stalls from the hazard unit and branch/jump redirects from decode/control.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
imem_addr  output  32  fetch address, word aligned.
imem_req  output  1  fetch request.
imem_ready  input  1  memory completes the request this cycle; imem_rdata valid.
imem_rdata  input  32  fetched instruction word.
stall  input  1  hold IF/ID contents (hazard unit).
branch_taken  input  1  redirect to branch_target.
branch_target  input  32  branch destination.
jump  input  1  redirect to jump target (from control, ID-stage instruction).
jump_index  input  26  instr[25:0] of the jump instruction.
instr  output  32  IF/ID instruction.
opcode  output  6  instr[31:26]; drives control unit.
pc_plus4  output  32  IF/ID PC+4 of instr.
valid  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; state=FETCH.
  - instr=0, opcode=0, pc_plus4=0, valid=0.
  - Skid register and redir_pc cleared.
  - imem_req is 1 from the first cycle after release.
- Redirect:
  - redirect = branch_taken | jump.
  - target = branch_taken ? branch_target : {pc_plus4[31:28], jump_index, 2'b00}. Branch wins if both are asserted.
  - Redirect always overrides stall and flushes IF/ID: valid<=0, instr<=0.
- Memory protocol: while imem_req=1, imem_addr must stay stable until imem_ready. A request is never withdrawn.
- imem_addr = pc in FETCH and DRAIN. imem_req = 1 in FETCH and DRAIN, 0 in HOLD.
- FETCH, imem_ready=1:
  - redirect: discard rdata; pc<=target; stay FETCH.
  - stall: skid<=rdata, skid_pc4<=pc+4; pc<=pc+4; IF/ID unchanged; go HOLD.
  - otherwise: instr<=rdata, pc_plus4<=pc+4, valid<=1; pc<=pc+4; stay FETCH.
- FETCH, imem_ready=0:
  - redirect: redir_pc<=target; IF/ID flushed; go DRAIN.
  - stall: IF/ID unchanged.
  - otherwise: bubble, valid<=0, instr<=0.
- HOLD:
  - redirect: discard skid; pc<=target; flush; go FETCH.
  - stall: hold.
  - otherwise: instr<=skid, pc_plus4<=skid_pc4, valid<=1; go FETCH. The next request issues that same cycle.
- DRAIN:
  - Wait for imem_ready, then discard the data; pc<=redir_pc; go FETCH.
  - A further redirect during DRAIN overwrites redir_pc (newest wins). If it coincides with ready, the new target is used.
  - Stall is ignored; valid stays 0.
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0. pc[1:0] is always 00; target bits [1:0] are forced to 00.
- State encoding: 2 bits. The unused encoding returns to FETCH.
- Latency: zero-wait memory with no stall gives one instruction per cycle; instr appears the cycle after the ready edge.

Test Plan:
- Reset/stream: RESET_PC=0, ready tied 1, mem[i]=i+1. After release: addr 0,4,8 on consecutive cycles. instr=1,2,3 with valid=1, pc_plus4=4,8,12. Reset asserted mid-stream → all outputs 0 immediately and imem_addr returns to 0.
- Wait states: ready asserted every 3rd cycle. addr held stable while waiting; valid=0 bubbles between; instr sequence still 1,2,3.
- Stall skid: stall=1 in the same cycle as ready for addr 8. IF/ID keeps word 2 and imem_req=0 in HOLD. After stall=0, instr=3 and the fetch of 12 issues.
- Branch flush: branch_taken=1 with branch_target=0x40 while the fetch of 8 completes. valid=0 next cycle, next addr=0x40, instr=mem[0x40].
- Drain: jump=1, pc_plus4=0x1000_0008, jump_index=0x10, while the fetch is pending with ready=0 for 4 cycles. addr held, then next addr=0x1000_0040, and the discarded word never sets valid. Also: branch_taken+jump together → branch_target used.
